// File: rtl/vga_pkg.sv
// Shared VGA 800x600@72 timing constants, colour type and layer priority helper.
// Sprite blocks take SCREEN_W/SCREEN_H from here.
package vga_pkg;
    localparam int H_VIS   = 800;
    localparam int H_FP    = 56;
    localparam int H_SYNC  = 120;
    localparam int H_BP    = 64;
    localparam int V_VIS   = 600;
    localparam int V_FP    = 37;
    localparam int V_SYNC  = 6;
    localparam int V_BP    = 23;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int SCREEN_W = H_VIS;
    localparam int SCREEN_H = V_VIS;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic SYNC_POL    = 1'b1;
    localparam int   ROM_LAT     = 1;
    localparam int   ANIM_FRAMES = 8;
    localparam int   N_LAYERS    = 4;

    typedef logic [11:0] rgb_t;
    typedef logic [9:0]  scan_t;

    // Lowest-index hit wins; background when no layer is opaque.
    function automatic rgb_t pick_layer(input logic [N_LAYERS-1:0]    hit,
                                        input logic [N_LAYERS*12-1:0] rgb,
                                        input rgb_t                   bg);
        rgb_t c;
        c = bg;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) c = rgb[12*i +: 12];
        end
        return c;
    endfunction
endpackage

// File: rtl/vga_compositor_if.sv
// Scan position out to sprite blocks, their hit/colour answers back, and the VGA pins.
interface vga_compositor_if;
    import vga_pkg::*;

    scan_t                    col;
    scan_t                    row;
    logic [N_LAYERS-1:0]      layer_hit;
    logic [N_LAYERS*12-1:0]   layer_rgb;
    rgb_t                     bg_rgb;
    logic [3:0]               vga_r;
    logic [3:0]               vga_g;
    logic [3:0]               vga_b;
    logic                     vga_hs;
    logic                     vga_vs;
    logic                     frame_tick;
    logic                     anim_tick;

    modport master (
        output col, row, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, anim_tick,
        input  layer_hit, layer_rgb, bg_rgb
    );

    modport slave (
        input  col, row, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick, anim_tick,
        output layer_hit, layer_rgb, bg_rgb
    );
endinterface

// File: rtl/sync_delay.sv
// N-stage shift register with an asynchronous reset value; aligns raw
// position flags with the sprite ROM latency.
module sync_delay #(
    parameter int             N       = 1,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_stage [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[N-1];
endmodule

// File: rtl/vga_compositor.sv
// VGA scan generator and 4-layer priority compositor with frame/animation ticks.
// Pins lag col/row by ROM_LAT+1 clocks; the ticks are not delayed.
module vga_compositor #(
    parameter int   H_VIS       = vga_pkg::H_VIS,
    parameter int   H_FP        = vga_pkg::H_FP,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BP        = vga_pkg::H_BP,
    parameter int   V_VIS       = vga_pkg::V_VIS,
    parameter int   V_FP        = vga_pkg::V_FP,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BP        = vga_pkg::V_BP,
    parameter logic SYNC_POL    = vga_pkg::SYNC_POL,
    parameter int   ROM_LAT     = vga_pkg::ROM_LAT,
    parameter int   ANIM_FRAMES = vga_pkg::ANIM_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    vga_compositor_if.master bus
);
    import vga_pkg::*;

    localparam int    H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int    V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam scan_t H_LAST    = scan_t'(H_TOT - 1);
    localparam scan_t V_LAST    = scan_t'(V_TOT - 1);
    localparam scan_t H_VIS_C   = scan_t'(H_VIS);
    localparam scan_t V_VIS_C   = scan_t'(V_VIS);
    localparam scan_t V_VIS_END = scan_t'(V_VIS - 1);
    localparam scan_t HS_START  = scan_t'(H_VIS + H_FP);
    localparam scan_t HS_END    = scan_t'(H_VIS + H_FP + H_SYNC);
    localparam scan_t VS_START  = scan_t'(V_VIS + V_FP);
    localparam scan_t VS_END    = scan_t'(V_VIS + V_FP + V_SYNC);
    localparam int    FC_W      = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(ANIM_FRAMES - 1);

    scan_t           r_col;
    scan_t           r_row;
    rgb_t            r_rgb;
    logic            r_hs;
    logic            r_vs;
    logic            r_frame_tick;
    logic            r_anim_tick;
    logic [FC_W-1:0] r_frame_cnt;

    logic            w_col_wrap;
    logic            w_frame_edge;
    logic [2:0]      w_raw;
    logic [2:0]      w_raw_d;

    assign w_col_wrap   = (r_col == H_LAST);
    assign w_frame_edge = w_col_wrap && (r_row == V_VIS_END);

    // {vis, hs_raw, vs_raw}, all active-high; polarity is applied at the pins.
    assign w_raw[2] = (r_col < H_VIS_C) && (r_row < V_VIS_C);
    assign w_raw[1] = (r_col >= HS_START) && (r_col < HS_END);
    assign w_raw[0] = (r_row >= VS_START) && (r_row < VS_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_wrap ? '0 : r_col + 1'b1;
            if (w_col_wrap) r_row <= (r_row == V_LAST) ? '0 : r_row + 1'b1;
        end
    end

    sync_delay #(
        .N       (ROM_LAT),
        .W       (3),
        .RST_VAL (3'b000)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .i_d (w_raw),
        .o_q (w_raw_d)
    );

    // Blanking gates the layers here, so off-screen hits never reach the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
        end else begin
            r_rgb <= w_raw_d[2] ? pick_layer(bus.layer_hit, bus.layer_rgb, bus.bg_rgb) : '0;
            r_hs  <= w_raw_d[1] ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_raw_d[0] ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_anim_tick  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_tick <= w_frame_edge;
            r_anim_tick  <= 1'b0;
            if (w_frame_edge) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt <= '0;
                    r_anim_tick <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.col        = r_col;
    assign bus.row        = r_row;
    assign bus.vga_r      = r_rgb[11:8];
    assign bus.vga_g      = r_rgb[7:4];
    assign bus.vga_b      = r_rgb[3:0];
    assign bus.vga_hs     = r_hs;
    assign bus.vga_vs     = r_vs;
    assign bus.frame_tick = r_frame_tick;
    assign bus.anim_tick  = r_anim_tick;
endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench for vga_compositor on a shrunken raster (30 x 17) so whole
// frames and a 17-frame animation run stay short.
module tb_vga_compositor;
    localparam int HV  = 16;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 4;
    localparam int HT  = HV + HFP + HSY + HBP;
    localparam int VV  = 10;
    localparam int VFP = 2;
    localparam int VSY = 3;
    localparam int VBP = 2;
    localparam int VT  = VV + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int HSS = HV + HFP;
    localparam int HSE = HSS + HSY;
    localparam int VSS = VV + VFP;
    localparam int VSE = VSS + VSY;
    localparam int LAT = 2;

    localparam logic [47:0] LAYERS = {12'h456, 12'h0F0, 12'hF00, 12'h123};

    localparam int          PX [7] = '{5, 9, 0, 15, 7, 3, 15};
    localparam int          PY [7] = '{3, 3, 4, 4, 6, 9, 9};
    localparam logic [3:0]  PH [7] = '{4'b0110, 4'b0000, 4'b1111, 4'b1000, 4'b0100, 4'b1010, 4'b1100};
    localparam logic [11:0] PB [7] = '{12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h0AA, 12'h0AA};
    localparam logic [11:0] PE [7] = '{12'hF00, 12'h00F, 12'h123, 12'h456, 12'h0F0, 12'hF00, 12'h0F0};

    localparam int          BX [6] = '{15, 16, 29, 0, 3, 15};
    localparam int          BY [6] = '{7, 8, 9, 10, 11, 16};
    localparam logic [11:0] BE [6] = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   k_rel  = 0;
    logic [11:0] pins;

    vga_compositor_if bus();

    vga_compositor #(
        .H_VIS (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_VIS (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .SYNC_POL (1'b1), .ROM_LAT (1), .ANIM_FRAMES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign pins = {bus.vga_r, bus.vga_g, bus.vga_b};

    function automatic logic exp_hs(input int k);
        int p;
        if (k < LAT) return 1'b0;
        p = (k - LAT) % HT;
        return (p >= HSS) && (p < HSE);
    endfunction

    function automatic logic exp_vs(input int k);
        int r;
        if (k < LAT) return 1'b0;
        r = ((k - LAT) % FT) / HT;
        return (r >= VSS) && (r < VSE);
    endfunction

    function automatic logic exp_vis(input int k);
        int p;
        if (k < LAT) return 1'b0;
        p = (k - LAT) % FT;
        return ((p % HT) < HV) && ((p / HT) < VV);
    endfunction

    task automatic wait_pos(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * FT; n++) begin
            if (bus.col == 10'(x) && bus.row == 10'(y)) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.layer_hit = '0;
        bus.layer_rgb = LAYERS;
        bus.bg_rgb    = 12'hABC;
        repeat (3) @(negedge clk);
        checks++; if (bus.col !== 10'd0) begin errors++; $display("FAIL reset_col got %0d expected 0", bus.col); end
        checks++; if (bus.row !== 10'd0) begin errors++; $display("FAIL reset_row got %0d expected 0", bus.row); end
        checks++; if (pins !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h expected 000", pins); end
        checks++; if (bus.vga_hs !== 1'b0) begin errors++; $display("FAIL reset_hs got %b expected 0", bus.vga_hs); end
        checks++; if (bus.vga_vs !== 1'b0) begin errors++; $display("FAIL reset_vs got %b expected 0", bus.vga_vs); end
        checks++; if ({bus.frame_tick, bus.anim_tick} !== 2'b00) begin
            errors++; $display("FAIL reset_ticks got %b expected 00", {bus.frame_tick, bus.anim_tick});
        end
    endtask

    task automatic test_line_timing();
        int pos_bad = 0, hs_bad = 0, rgb_bad = 0, hs_cnt = 0, hs_first = -1;
        rst = 1'b0;
        for (int k = 0; k <= 2 * HT; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.col !== 10'(k % HT) || bus.row !== 10'(k / HT)) pos_bad++;
            if (bus.vga_hs !== exp_hs(k)) hs_bad++;
            if (pins !== (exp_vis(k) ? 12'hABC : 12'h000)) rgb_bad++;
            if (bus.vga_hs === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
        end
        k_rel = 2 * HT;
        checks++; if (pos_bad != 0) begin errors++; $display("FAIL line_colrow bad_cycles=%0d expected 0", pos_bad); end
        checks++; if (hs_bad != 0) begin errors++; $display("FAIL line_hs bad_cycles=%0d expected 0", hs_bad); end
        checks++; if (rgb_bad != 0) begin errors++; $display("FAIL line_rgb bad_cycles=%0d expected 0", rgb_bad); end
        checks++; if (hs_cnt != 2 * HSY) begin errors++; $display("FAIL line_hs_width got %0d expected %0d", hs_cnt, 2 * HSY); end
        checks++; if (hs_first != HSS + LAT) begin errors++; $display("FAIL line_hs_start got %0d expected %0d", hs_first, HSS + LAT); end
    endtask

    task automatic test_frame_timing();
        int vs_bad = 0, hs_bad = 0, rgb_bad = 0, vs_cnt = 0, vs_first = -1;
        int ft_cnt = 0, ft_k = -1, anim_cnt = 0;
        logic [9:0] ft_col = '1, ft_row = '1;
        for (int k = k_rel + 1; k <= FT + HT; k++) begin
            @(negedge clk);
            if (bus.vga_vs !== exp_vs(k)) vs_bad++;
            if (bus.vga_hs !== exp_hs(k)) hs_bad++;
            if (pins !== (exp_vis(k) ? 12'hABC : 12'h000)) rgb_bad++;
            if (bus.vga_vs === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            if (bus.frame_tick === 1'b1) begin
                ft_cnt++;
                ft_k = k;
                ft_col = bus.col;
                ft_row = bus.row;
            end
            if (bus.anim_tick === 1'b1) anim_cnt++;
        end
        k_rel = FT + HT;
        checks++; if (vs_bad != 0) begin errors++; $display("FAIL frame_vs bad_cycles=%0d expected 0", vs_bad); end
        checks++; if (hs_bad != 0 || rgb_bad != 0) begin
            errors++; $display("FAIL frame_hs_rgb bad_cycles=%0d/%0d expected 0/0", hs_bad, rgb_bad);
        end
        checks++; if (vs_cnt != VSY * HT) begin errors++; $display("FAIL frame_vs_width got %0d expected %0d", vs_cnt, VSY * HT); end
        checks++; if (vs_first != VSS * HT + LAT) begin errors++; $display("FAIL frame_vs_start got %0d expected %0d", vs_first, VSS * HT + LAT); end
        checks++; if (ft_cnt != 1) begin errors++; $display("FAIL frame_tick_count got %0d expected 1", ft_cnt); end
        checks++; if (ft_k != VV * HT || ft_col !== 10'd0 || ft_row !== 10'(VV)) begin
            errors++; $display("FAIL frame_tick_pos got cyc=%0d col=%0d row=%0d expected cyc=%0d col=0 row=%0d",
                               ft_k, ft_col, ft_row, VV * HT, VV);
        end
        checks++; if (anim_cnt != 0) begin errors++; $display("FAIL frame_anim got %0d expected 0", anim_cnt); end
    endtask

    task automatic test_priority();
        bit ok;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            wait_pos(PX[i], PY[i], ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL priority_wait[%0d] position (%0d,%0d) not reached", i, PX[i], PY[i]);
            end else begin
                @(negedge clk);
                bus.layer_hit = PH[i];
                bus.layer_rgb = LAYERS;
                bus.bg_rgb    = PB[i];
                @(negedge clk);
                if (pins !== PE[i]) begin
                    errors++; $display("FAIL priority[%0d] (%0d,%0d) got %h expected %h", i, PX[i], PY[i], pins, PE[i]);
                end
                bus.layer_hit = '0;
                bus.bg_rgb    = '0;
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wait_pos(BX[i], BY[i], ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL blank_wait[%0d] position (%0d,%0d) not reached", i, BX[i], BY[i]);
            end else begin
                @(negedge clk);
                bus.layer_hit = 4'hF;
                bus.layer_rgb = {4{12'hFFF}};
                bus.bg_rgb    = 12'hFFF;
                @(negedge clk);
                if (pins !== BE[i]) begin
                    errors++; $display("FAIL blank[%0d] (%0d,%0d) got %h expected %h", i, BX[i], BY[i], pins, BE[i]);
                end
                bus.layer_hit = '0;
                bus.bg_rgb    = '0;
            end
        end
        bus.layer_rgb = LAYERS;
    endtask

    task automatic test_anim_tick();
        int ft_n = 0, first_ft = -1, last_ft = -1, period_bad = 0;
        int anim_n = 0, orphan = 0;
        int anim_idx [2] = '{-1, -1};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 17 * FT + 10; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                ft_n++;
                if (first_ft < 0) first_ft = k;
                if (last_ft >= 0 && k - last_ft != FT) period_bad++;
                last_ft = k;
            end
            if (bus.anim_tick === 1'b1) begin
                if (bus.frame_tick !== 1'b1) orphan++;
                if (anim_n < 2) anim_idx[anim_n] = ft_n;
                anim_n++;
            end
        end
        checks++; if (ft_n != 17) begin errors++; $display("FAIL anim_frame_count got %0d expected 17", ft_n); end
        checks++; if (first_ft != VV * HT) begin errors++; $display("FAIL anim_first_frame got %0d expected %0d", first_ft, VV * HT); end
        checks++; if (period_bad != 0) begin errors++; $display("FAIL frame_period bad=%0d expected 0 (period %0d)", period_bad, FT); end
        checks++; if (anim_n != 2) begin errors++; $display("FAIL anim_count got %0d expected 2", anim_n); end
        checks++; if (anim_idx[0] != 8 || anim_idx[1] != 16) begin
            errors++; $display("FAIL anim_frames got %0d,%0d expected 8,16", anim_idx[0], anim_idx[1]);
        end
        checks++; if (orphan != 0) begin errors++; $display("FAIL anim_without_frame got %0d expected 0", orphan); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int ft_k = -1;
        bus.layer_hit = '0;
        bus.bg_rgb    = 12'hABC;
        @(negedge clk);
        wait_pos(HSS + 4, VSS + 1, ok);
        checks++;
        if (!ok || bus.vga_hs !== 1'b1 || bus.vga_vs !== 1'b1) begin
            errors++; $display("FAIL areset_pre_sync reached=%0d hs=%b vs=%b expected 1 1 1", ok, bus.vga_hs, bus.vga_vs);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.vga_hs !== 1'b0 || bus.vga_vs !== 1'b0 || bus.col !== 10'd0 || bus.row !== 10'd0) begin
            errors++; $display("FAIL areset_sync got hs=%b vs=%b col=%0d row=%0d expected 0 0 0 0",
                               bus.vga_hs, bus.vga_vs, bus.col, bus.row);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_pos(8, 5, ok);
        checks++;
        if (!ok || pins !== 12'hABC) begin
            errors++; $display("FAIL areset_pre_rgb reached=%0d got %h expected ABC", ok, pins);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (pins !== 12'h000) begin errors++; $display("FAIL areset_rgb got %h expected 000", pins); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= FT; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.col !== 10'd1 || bus.row !== 10'd0) begin
                    errors++; $display("FAIL areset_restart got col=%0d row=%0d expected 1 0", bus.col, bus.row);
                end
            end
            if (bus.frame_tick === 1'b1 && ft_k < 0) ft_k = k;
        end
        checks++; if (ft_k != VV * HT) begin errors++; $display("FAIL areset_first_frame got %0d expected %0d", ft_k, VV * HT); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_priority();
        test_blanking();
        test_anim_tick();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_compositor.md
Name: vga_compositor

Overview:
- Drives the 800x600 VGA output.
- Generates the scan position (col/row) that every sprite block consumes, and accepts their hit/colour answers back.
- Priority-muxes up to four sprite layers over a background colour and emits pixel RGB plus hsync/vsync, delay-aligned to sprite ROM latency.
- Also produces the per-frame game-update tick and the animation toggle tick for sprite blocks.

Parameters:
H_VIS, 800, visible pixels per line
H_FP, 56, horizontal front porch
H_SYNC, 120, hsync width
H_BP, 64, horizontal back porch (H_TOTAL = 1040)
V_VIS, 600, visible lines
V_FP, 37, vertical front porch
V_SYNC, 6, vsync width
V_BP, 23, vertical back porch (V_TOTAL = 666)
SYNC_POL, 1, active level of hs/vs
ROM_LAT, 1, clocks from col/row to sprite hit/rgb valid (1..3)
ANIM_FRAMES, 8, frames per anim_tick (>= 1)

Ports:
clk  in  1  pixel clock, one pixel per cycle (50 MHz for 800x600@72)
rst  in  1  asynchronous, active-high reset
col  out  10  current horizontal scan count, 0..H_TOTAL-1
row  out  10  current vertical scan count, 0..V_TOTAL-1
layer_hit  in  4  per-layer opaque flag; bit 0 is highest priority
layer_rgb  in  48  per-layer 12-bit colour; bits [12i+11:12i] belong to layer i
bg_rgb  in  12  background colour for the same pixel
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hs  out  1  hsync
vga_vs  out  1  vsync
frame_tick  out  1  one-cycle pulse, start of vertical blank
anim_tick  out  1  one-cycle pulse every ANIM_FRAMES frames

Behaviour:
- Reset (async, any time): col = 0, row = 0, RGB = 0, hs = vs = ~SYNC_POL, both ticks 0, delay pipeline filled with "not visible, sync inactive", frame counter 0. The scan restarts at (0,0) on the first edge after release.
- Counters:
  - col increments every clk and wraps H_TOTAL-1 -> 0.
  - row increments only when col wraps, and wraps V_TOTAL-1 -> 0.
  - col/row are registers, not combinational.
- Raw per-position signals:
  - vis = col < H_VIS && row < V_VIS.
  - hs_raw active when H_VIS+H_FP <= col < H_VIS+H_FP+H_SYNC.
  - vs_raw active when V_VIS+V_FP <= row < V_VIS+V_FP+V_SYNC, for entire lines.
- Alignment: layer_hit/layer_rgb/bg_rgb sampled at edge t belong to the col/row value held during the ROM_LAT cycles before t. vis, hs_raw and vs_raw pass through a ROM_LAT-stage delay to meet them.
- Compositor register, one clock:
  - If the delayed vis is 0, RGB = 0.
  - Otherwise RGB = rgb of the lowest-index set layer_hit bit, else bg_rgb.
  - hs/vs register in the same stage.
  - Total latency from col/row to pins = ROM_LAT+1 clocks, identical for RGB, hs and vs.
- Blanking overrides layers: layer hits outside the visible area never reach the pins.
- frame_tick:
  - Asserted for exactly one cycle after the edge where col = H_TOTAL-1 and row = V_VIS-1, i.e. while row = V_VIS, col = 0.
  - It is not delayed; game logic uses it to move sprites during vblank.
- anim_tick:
  - A frame counter runs 0..ANIM_FRAMES-1 and increments on each frame_tick.
  - anim_tick pulses in the same cycle as the frame_tick that wraps the counter.
  - With ANIM_FRAMES = 1, anim_tick equals frame_tick.
- Widths: 10-bit counters suffice (max 1039). Comparisons are unsigned against constants; no signed arithmetic.
- Reset mid-line: the sync pins return to inactive in the same cycle, asynchronously; no partial-sync glitch is required beyond that.

Decomposition:
- Shared package `vga_pkg`:
  - timing constants and derived H_TOTAL/V_TOTAL
  - sync start/end localparams
  - 12-bit rgb type and layer count (4)
  - sprite blocks reuse SCREEN_W/SCREEN_H from this package
- One sub-module, `sync_delay`: a parameterised N-stage shift register with async reset value. It is used for the vis/hs/vs alignment so ROM_LAT stays a single parameter.

Test Plan:
- Line timing: release reset, run 2 lines.
  - col sequence 0..1039 then 0; row increments at col 1039->0.
  - vga_hs active for exactly 120 cycles, starting ROM_LAT+1 = 2 clocks after col = 856.
- Frame timing: run one frame.
  - vga_vs active for 6 x 1040 cycles, starting after row reaches 637.
  - frame_tick high exactly once, at row = 600, col = 0.
  - Frame period 692,640 clocks.
- Priority:
  - Drive bg_rgb = 0x00F, layer_hit = 0b0110, layer1 = 0xF00, layer2 = 0x0F0 for pixel (100,50) -> output pixel = 0xF00.
  - Then layer_hit = 0 -> 0x00F.
- Blanking: at col = 850, layer_hit = 0xF with all layers 0xFFF -> RGB pins stay 0 two clocks later.
- Anim tick: ANIM_FRAMES = 8, run 17 frames -> anim_tick pulses exactly twice, coincident with the 8th and 16th frame_tick.
- Async reset mid-frame: assert rst at row 300, col 400 between edges.
  - Pins go to 0 / inactive immediately.
  - After release, col/row restart at 0,0 and the first frame_tick arrives 600 x 1040 clocks later.
